// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath (master) and the
// stall controller (slave): ID-stage operands, EX/MEM producer info, stall/flush controls.
interface hazard_stall_ctrl_if;
    localparam int unsigned REG_W = 5;

    // ID-stage consumer
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic             BranchTaken;

    // EX/MEM producers
    logic             EX_RegWrite;
    logic             EX_MemRead;
    logic [REG_W-1:0] EX_WriteReg;
    logic             MEM_RegWrite;
    logic             MEM_MemRead;
    logic [REG_W-1:0] MEM_WriteReg;

    // Pipeline control back to the datapath
    logic             PCWrite;
    logic             IFID_Write;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic             Stall;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, BranchTaken,
        output EX_RegWrite, EX_MemRead, EX_WriteReg,
        output MEM_RegWrite, MEM_MemRead, MEM_WriteReg,
        input  PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, Stall
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, BranchTaken,
        input  EX_RegWrite, EX_MemRead, EX_WriteReg,
        input  MEM_RegWrite, MEM_MemRead, MEM_WriteReg,
        output PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, Stall
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-operand hazard stall and branch flush control for a 5-stage pipeline.
// Optional feature: define STALL_COUNT_EN to add the saturating stall_cycles counter port.
module hazard_stall_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    hazard_stall_ctrl_if.slave     hz
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned NEED_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              nextState;
    state_t              curState;
    logic                remain;
    logic                nextRemain;
    logic                matchEx;
    logic                matchMem;
    logic [NEED_W-1:0]   need;
    logic                stallC;

    // Producer-to-consumer register matches; $0 is hardwired and never a hazard.
    always_comb begin
        matchEx  = hz.EX_RegWrite && (hz.EX_WriteReg != REG_W'(0)) &&
                   ((hz.EX_WriteReg == hz.ID_Rs) ||
                    (hz.ID_UsesRt && (hz.EX_WriteReg == hz.ID_Rt)));
        matchMem = hz.MEM_RegWrite && (hz.MEM_WriteReg != REG_W'(0)) &&
                   ((hz.MEM_WriteReg == hz.ID_Rs) ||
                    (hz.ID_UsesRt && (hz.MEM_WriteReg == hz.ID_Rt)));
    end

    // Stall need: branches compare in ID so they wait on EX ALU results and MEM loads too.
    always_comb begin
        need = NEED_W'(0);
        if (hz.ID_Branch && hz.EX_MemRead && matchEx) begin
            need = NEED_W'(2);
        end else if ((hz.ID_Branch && !hz.EX_MemRead && matchEx) ||
                     (hz.ID_Branch && hz.MEM_MemRead && matchMem) ||
                     (!hz.ID_Branch && hz.EX_MemRead && matchEx)) begin
            need = NEED_W'(1);
        end
    end

    // While reset is held the controller behaves as if in IDLE.
    assign curState = reset ? IDLE : state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            remain <= 1'b0;
        end else begin
            state  <= nextState;
            remain <= nextRemain;
        end
    end

    // Next state and stall decision; HOLD counts down the extra branch-after-load cycle.
    always_comb begin
        nextState  = IDLE;
        nextRemain = 1'b0;
        stallC     = 1'b0;
        unique case (curState)
            IDLE: begin
                stallC = (need != NEED_W'(0));
                if (need == NEED_W'(2)) begin
                    nextState  = HOLD;
                    nextRemain = 1'b1;
                end
            end
            HOLD: begin
                stallC     = 1'b1;
                nextRemain = remain - 1'b1;
                nextState  = IDLE;
            end
        endcase
    end

    // Stall freezes PC and IF/ID and injects a bubble; a flush never overlaps a stall.
    always_comb begin
        hz.Stall       = stallC;
        hz.PCWrite     = !stallC;
        hz.IFID_Write  = !stallC;
        hz.IDEX_Bubble = stallC;
        hz.IFID_Flush  = hz.ID_Branch && hz.BranchTaken && !stallC;
    end

`ifdef STALL_COUNT_EN
    localparam int unsigned CNT_W = 32;

    // Saturating performance counter of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= CNT_W'(0);
        end else if (stallC && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl; counter checks appear when STALL_COUNT_EN is defined.
module tb_hazard_stall_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    hazard_stall_ctrl_if hzIf ();

`ifdef STALL_COUNT_EN
    logic [31:0] stallCycles;
`endif

    hazard_stall_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .hz           (hzIf.slave)
`ifdef STALL_COUNT_EN
        ,
        .stall_cycles (stallCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkOuts(input string tag, input logic expStall, input logic expFlush);
        checkVal({tag, ".Stall"},       32'(hzIf.Stall),       32'(expStall));
        checkVal({tag, ".PCWrite"},     32'(hzIf.PCWrite),     32'(!expStall));
        checkVal({tag, ".IFID_Write"},  32'(hzIf.IFID_Write),  32'(!expStall));
        checkVal({tag, ".IDEX_Bubble"}, 32'(hzIf.IDEX_Bubble), 32'(expStall));
        checkVal({tag, ".IFID_Flush"},  32'(hzIf.IFID_Flush),  32'(expFlush));
    endtask

    // Drive one full input vector and let combinational outputs settle.
    task automatic drive(input logic br, input logic taken,
                         input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                         input logic exRw, input logic exMr, input logic [4:0] exWr,
                         input logic memRw, input logic memMr, input logic [4:0] memWr);
        hzIf.ID_Branch    = br;
        hzIf.BranchTaken  = taken;
        hzIf.ID_Rs        = rs;
        hzIf.ID_Rt        = rt;
        hzIf.ID_UsesRt    = usesRt;
        hzIf.EX_RegWrite  = exRw;
        hzIf.EX_MemRead   = exMr;
        hzIf.EX_WriteReg  = exWr;
        hzIf.MEM_RegWrite = memRw;
        hzIf.MEM_MemRead  = memMr;
        hzIf.MEM_WriteReg = memWr;
        #1;
    endtask

    task automatic benign();
        drive(1'b0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        benign();

        // Reset: idle outputs, but still a live combinational function of inputs
        nextCycle();
        benign();
        checkOuts("rst_idle", 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0);
        checkOuts("rst_comb", 1'b1, 1'b0);
        nextCycle();
        reset = 1'b0;
        benign();
        checkOuts("post_rst", 1'b0, 1'b0);
`ifdef STALL_COUNT_EN
        checkVal("cnt_rst", stallCycles, 32'd0);
`endif

        // lw $8 in EX, add using $8 in ID: one stall cycle
        nextCycle();
        drive(1'b0, 1'b0, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0);
        checkOuts("loaduse_s1", 1'b1, 1'b0);
        nextCycle();
        drive(1'b0, 1'b0, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd8);
        checkOuts("loaduse_done", 1'b0, 1'b0);

        // lw $9 in EX, beq reading $9 via Rt: IDLE stall then HOLD, flush suppressed
        nextCycle();
        drive(1'b1, 1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0);
        checkOuts("brload_s1", 1'b1, 1'b0);
        nextCycle();
        drive(1'b1, 1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd9);
        checkOuts("brload_hold", 1'b1, 1'b0);
        nextCycle();
        drive(1'b1, 1'b0, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        checkOuts("brload_done", 1'b0, 1'b0);
`ifdef STALL_COUNT_EN
        checkVal("cnt_brload", stallCycles, 32'd3);
`endif

        // add $5 in EX, beq on $5: one stall, then taken branch flushes
        nextCycle();
        drive(1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0);
        checkOuts("bralu_s1", 1'b1, 1'b0);
        nextCycle();
        drive(1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5);
        checkOuts("bralu_flush", 1'b0, 1'b1);

        // $0 never matches
        nextCycle();
        drive(1'b0, 1'b0, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        checkOuts("zero_reg", 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0);
        checkOuts("zero_reg_br", 1'b0, 1'b0);

        // Branch on a MEM-stage load via Rt: single stall; ignored when Rt unused
        nextCycle();
        drive(1'b1, 1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7);
        checkOuts("brmem_s1", 1'b1, 1'b0);
        nextCycle();
        benign();
        checkOuts("brmem_done", 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7);
        checkOuts("rt_unused", 1'b0, 1'b0);

        // Forwardable ALU result for non-branch, and non-writing MEM load: no stall
        drive(1'b0, 1'b0, 5'd4, 5'd2, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 5'd0);
        checkOuts("alu_fwd", 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'd4, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4);
        checkOuts("mem_norw", 1'b0, 1'b1);

        // After HOLD a new hazard starts a fresh stall
        nextCycle();
        drive(1'b1, 1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0);
        checkOuts("rearm_s1", 1'b1, 1'b0);
        nextCycle();
        benign();
        checkOuts("rearm_hold", 1'b1, 1'b0);
        nextCycle();
        drive(1'b0, 1'b0, 5'd10, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 5'd0);
        checkOuts("rearm_new", 1'b1, 1'b0);
        nextCycle();
        benign();
        checkOuts("rearm_done", 1'b0, 1'b0);

        // Reset asserted in HOLD cancels the remaining stall
        nextCycle();
        drive(1'b1, 1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0);
        checkOuts("rsthold_s1", 1'b1, 1'b0);
        nextCycle();
        reset = 1'b1;
        benign();
        checkOuts("rsthold_in", 1'b0, 1'b0);
        nextCycle();
        reset = 1'b0;
        benign();
        checkOuts("rsthold_after", 1'b0, 1'b0);
`ifdef STALL_COUNT_EN
        checkVal("cnt_rsthold", stallCycles, 32'd0);

        // Counter saturation from a preloaded near-max value
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles;
        drive(1'b0, 1'b0, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkVal("cnt_sat", stallCycles, 32'hFFFF_FFFF);
        nextCycle();
        checkVal("cnt_sat_hold", stallCycles, 32'hFFFF_FFFF);
        benign();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock and reset ports are listed first.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock shared with the register file and pipeline registers.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-004 The block SHALL have port ID_Rs, input, 5 bits: source register of the ID-stage instruction (instr[25:21]).
REQ-005 The block SHALL have port ID_Rt, input, 5 bits: source register of the ID-stage instruction (instr[20:16]).
REQ-006 The block SHALL have port ID_UsesRt, input, 1 bit: the ID instruction reads Rt.
REQ-007 The block SHALL have port ID_Branch, input, 1 bit: the ID instruction is beq/bne, resolved in ID by the register-file comparator.
REQ-008 The block SHALL have port BranchTaken, input, 1 bit: comparator outcome qualified by the branch type.
REQ-009 The block SHALL have ports EX_RegWrite, EX_MemRead (input, 1 bit each) and EX_WriteReg (input, 5 bits): EX-stage producer information.
REQ-010 The block SHALL have ports MEM_RegWrite, MEM_MemRead (input, 1 bit each) and MEM_WriteReg (input, 5 bits): MEM-stage producer information.
REQ-011 The block SHALL have outputs PCWrite, IFID_Write, IDEX_Bubble and IFID_Flush, 1 bit each.
REQ-012 The block SHALL have output Stall, 1 bit: a stall is active this cycle.
REQ-013 The block SHALL have output stall_cycles, 32 bits, present only when STALL_COUNT_EN is defined.

Function
REQ-014 matchX SHALL be X_RegWrite & (X_WriteReg != 0) & ((X_WriteReg == ID_Rs) | (ID_UsesRt & (X_WriteReg == ID_Rt))), for X = EX or MEM; register 0 never matches.
REQ-015 The stall need N SHALL be 2 when ID_Branch & EX_MemRead & matchEX.
REQ-016 Otherwise N SHALL be 1 when any of the following holds: (ID_Branch & !EX_MemRead & matchEX), (ID_Branch & MEM_MemRead & matchMEM), or (!ID_Branch & EX_MemRead & matchEX).
REQ-017 Otherwise N SHALL be 0.
REQ-018 The FSM SHALL have states IDLE and HOLD, and a 1-bit register remain.
REQ-019 In IDLE, Stall SHALL be combinationally (N != 0); if N == 2, the next state SHALL be HOLD with remain = 1; otherwise the FSM SHALL stay in IDLE.
REQ-020 In HOLD, Stall SHALL be 1 regardless of inputs; detection SHALL be ignored; the next state SHALL be IDLE.
REQ-021 The stall outputs SHALL be PCWrite = !Stall, IFID_Write = !Stall and IDEX_Bubble = Stall.
REQ-022 IFID_Flush SHALL be ID_Branch & BranchTaken & !Stall; a flush is never asserted in a stall cycle.
REQ-023 The total stall length SHALL be exactly 2 cycles for branch-after-load, 1 cycle for the other N = 1 cases, and 0 cycles otherwise.
REQ-024 After HOLD, IDLE SHALL re-evaluate the inputs; a new hazard seen then starts a fresh stall.
REQ-025 Forwarding is out of scope; the block SHALL only stall and flush.

Reset
REQ-026 On reset = 1 at a clock edge, the block SHALL go to state IDLE with remain = 0 and stall_cycles = 0.
REQ-027 Reset SHALL override HOLD mid-stall; no residual stall appears after reset.
REQ-028 While reset is high, outputs SHALL remain a combinational function of state IDLE and the current inputs.

Configuration
REQ-029 With STALL_COUNT_EN defined, stall_cycles SHALL increment by 1 on each clock edge where Stall = 1 and reset = 0, saturating at 0xFFFFFFFF.
REQ-030 With STALL_COUNT_EN undefined, the stall_cycles port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 lw $8 in EX (EX_MemRead = 1, EX_RegWrite = 1, EX_WriteReg = 8), ID add with Rs = 8 -> Stall = 1 for exactly 1 cycle, PCWrite = 0, IDEX_Bubble = 1.
REQ-032 lw $9 in EX, ID beq with Rt = 9 and ID_UsesRt = 1 -> Stall = 1 for 2 consecutive cycles (IDLE, HOLD), then 0; stall_cycles increases by 2.
REQ-033 add $5 in EX (EX_MemRead = 0), ID beq with Rs = 5 -> 1 stall cycle; the following cycle, with BranchTaken = 1 -> IFID_Flush = 1 and Stall = 0.
REQ-034 EX_WriteReg = 0 with EX_RegWrite = 1 and EX_MemRead = 1, ID Rs = 0 -> Stall stays 0.
REQ-035 Enter HOLD, then assert reset in the HOLD cycle -> the next cycle is IDLE, Stall = 0 with benign inputs, and stall_cycles = 0.
REQ-036 Preload stall_cycles to 0xFFFFFFFE (force), then apply 3 stall cycles -> stall_cycles = 0xFFFFFFFF and holds.
